alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
Multi-cycle issue/writeback controller that drives the team's 16-bit combinational ALU interface (a, b, 3-bit operation, operand select) and consumes its result. It accepts 16-bit instructions over a valid/ready handshake and reads operands from an internal 8x16 register file. Each instruction is issued to the ALU, the result is captured and written back, and completion is signalled. It sits between the instruction source and the ALU in the 16-bit CPU datapath.

Parameters:
NREGS, 8, number of architectural registers (fixed at 8; the 3-bit register fields assume it)
WIDTH, 16, datapath width; must match the ALU

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction present
instr_ready  out  1  controller can accept an instruction; combinational, high only in IDLE
instr  in  16  [15:13] op, [12] operand, [11:9] rd, [8:6] rs1, [5:3] rs2, [2:0] reserved (ignored)
ext_wr_en  in  1  external register-file write (preload)
ext_wr_addr  in  3  external write address
ext_wr_data  in  16  external write data
dbg_rd_addr  in  3  debug read address
dbg_rd_data  out  16  combinational register-file read; R0 reads 0
alu_a  out  16  registered ALU operand a
alu_b  out  16  registered ALU operand b
alu_operation  out  3  registered ALU operation code
alu_operand  out  1  registered ALU operand select (1 = a, 0 = b for NOT/SHL/SHR)
alu_result  in  16  combinational ALU result
done  out  1  one-cycle pulse: writeback occurred
result_out  out  16  last written-back result, held until the next writeback
zero_flag  out  1  high when result_out == 0, updated only at writeback

Behaviour:
- Reset (async, rst_n=0):
  - state to IDLE.
  - All registers R0-R7 to 0.
  - alu_a, alu_b, alu_operation, alu_operand, done, result_out to 0; zero_flag to 1.
  - Takes effect immediately mid-operation; any in-flight instruction is discarded with no writeback and no done.
- State machine IDLE -> READ -> EXEC -> IDLE:
  - IDLE: instr_ready=1. On an edge with instr_valid=1, latch instr into the internal IR and go to READ.
  - READ: on the edge, alu_a<=R[rs1], alu_b<=R[rs2], alu_operation<=IR[15:13], alu_operand<=IR[12]; go to EXEC.
  - EXEC: alu_* are stable and the ALU settles combinationally. On the edge, R[rd]<=alu_result (if rd!=0), result_out<=alu_result, zero_flag<=(alu_result==0), done<=1; go to IDLE.
- Latency: accept at edge N; done is high in the cycle following edge N+2. instr_ready is high in that same cycle, so back-to-back throughput is 1 instruction per 3 cycles.
- done is low in every other cycle.
- alu_* outputs hold their last values outside READ (no return to 0).
- R0 is hardwired: it always reads 0, and writes to it (writeback or external) are ignored. result_out and done still update when rd=0.
- ext_wr_en:
  - Honoured only in IDLE; ignored in READ and EXEC.
  - If it coincides with an instruction accept in IDLE, both take effect. READ then sees the newly written value, because operands are read one cycle after accept.
- rs1==rs2 and rd==rs1/rs2 are legal. Operands are read in READ, before writeback, so no hazard exists.
- Arithmetic is modulo 2^16 and performed entirely in the ALU. The controller applies no sign or carry handling.
- instr_valid while not in IDLE is ignored (ready=0, no accept). The instruction source must hold the instruction until ready.

Optional Feature:
ISSUE_COUNT_EN
- Defined: adds output retired_count [15:0].
  - Reset to 0; increments by 1 on each EXEC->IDLE writeback edge.
  - Wraps from 0xFFFF to 0x0000.
  - Not incremented for instructions discarded by reset.
- Undefined: the port is absent and there is no counter logic; all other behaviour is identical.

Test Plan:
- Preload R1=0x1234, R2=0x00FF; instr op=000 rd=3 rs1=1 rs2=2 -> done 3 cycles after accept, result_out=0x1333, dbg R3=0x1333, zero_flag=0.
- R1=0x0000, R2=0x0001; op=001 (sub) rd=4 -> R4=0xFFFF (wrap). Then op=100 rd=5 rs1=4 rs2=4 -> R5=0x0000, zero_flag=1.
- R6=0x8001; op=110 operand=1 rs1=6 rd=7 -> R7=0x0002. Op=101 operand=0 rs2=6 rd=7 -> R7=0x7FFE.
- Writeback with rd=0 (add R1+R2) -> done=1, result_out=0x1333, dbg R0 still 0. ext_wr to R0 -> still 0.
- Hold instr_valid high continuously for 3 instructions -> accepts exactly every 3rd cycle. ext_wr_en during READ/EXEC is ignored (target register unchanged).
- Assert rst_n low during EXEC -> no done, rd unchanged (0), outputs at reset values; first instruction after release behaves normally. With ISSUE_COUNT_EN, retired_count equals the number of completed writebacks.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the 16-bit combinational ALU: IDLE -> READ -> EXEC -> IDLE.
// Optional retired-instruction counter output enabled by defining ISSUE_COUNT_EN.
module alu_issue_ctrl #(
   parameter int NREGS = 8,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             instr_valid,
   output logic             instr_ready,
   input  logic [15:0]      instr,
   input  logic             ext_wr_en,
   input  logic [2:0]       ext_wr_addr,
   input  logic [WIDTH-1:0] ext_wr_data,
   input  logic [2:0]       dbg_rd_addr,
   output logic [WIDTH-1:0] dbg_rd_data,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_operation,
   output logic             alu_operand,
   input  logic [WIDTH-1:0] alu_result,
   output logic             done,
   output logic [WIDTH-1:0] result_out,
   output logic             zero_flag
`ifdef ISSUE_COUNT_EN
   ,
   output logic [15:0]      retired_count
`endif
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_READ = 2'd1;
   localparam logic [1:0] ST_EXEC = 2'd2;

   logic [1:0]                   state_r;
   logic [1:0]                   state_nxt_s;
   logic [12:0]                  ir_r;
   logic [NREGS-1:0][WIDTH-1:0]  regs_r;
   logic [WIDTH-1:0]             alu_a_r;
   logic [WIDTH-1:0]             alu_b_r;
   logic [2:0]                   alu_operation_r;
   logic                         alu_operand_r;
   logic                         done_r;
   logic [WIDTH-1:0]             result_out_r;
   logic                         zero_flag_r;
   logic [2:0]                   ir_op_s;
   logic                         ir_operand_s;
   logic [2:0]                   ir_rd_s;
   logic [2:0]                   ir_rs1_s;
   logic [2:0]                   ir_rs2_s;
   logic                         unused_reserved_s;

   // R0 is hardwired to zero regardless of storage contents.
   function automatic logic [WIDTH-1:0] rf_read(input logic [NREGS-1:0][WIDTH-1:0] rf,
                                                input logic [2:0] idx);
      logic [WIDTH-1:0] val;
      if (idx == 3'd0) begin
         val = {WIDTH{1'b0}};
      end else begin
         val = rf[idx];
      end
      return val;
   endfunction

   function automatic logic is_zero(input logic [WIDTH-1:0] val);
      return (val == {WIDTH{1'b0}});
   endfunction

   assign ir_op_s           = ir_r[12:10];
   assign ir_operand_s      = ir_r[9];
   assign ir_rd_s           = ir_r[8:6];
   assign ir_rs1_s          = ir_r[5:3];
   assign ir_rs2_s          = ir_r[2:0];
   assign unused_reserved_s = ^instr[2:0];

   assign instr_ready   = (state_r == ST_IDLE);
   assign dbg_rd_data   = rf_read(regs_r, dbg_rd_addr);
   assign alu_a         = alu_a_r;
   assign alu_b         = alu_b_r;
   assign alu_operation = alu_operation_r;
   assign alu_operand   = alu_operand_r;
   assign done          = done_r;
   assign result_out    = result_out_r;
   assign zero_flag     = zero_flag_r;

   // Next-state decode; instructions are only accepted from IDLE.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (instr_valid) begin
               state_nxt_s = ST_READ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_READ: state_nxt_s = ST_EXEC;
         ST_EXEC: state_nxt_s = ST_IDLE;
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Instruction register; the reserved low bits are never stored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_r <= 13'd0;
      end else if ((state_r == ST_IDLE) && instr_valid) begin
         ir_r <= instr[15:3];
      end
   end

   // Register file: preload only in IDLE, writeback only in EXEC, so the two never collide.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_r <= {(NREGS*WIDTH){1'b0}};
      end else if ((state_r == ST_IDLE) && ext_wr_en && (ext_wr_addr != 3'd0)) begin
         regs_r[ext_wr_addr] <= ext_wr_data;
      end else if ((state_r == ST_EXEC) && (ir_rd_s != 3'd0)) begin
         regs_r[ir_rd_s] <= alu_result;
      end
   end

   // ALU operand/opcode registers; loaded in READ and held otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_a_r         <= {WIDTH{1'b0}};
         alu_b_r         <= {WIDTH{1'b0}};
         alu_operation_r <= 3'd0;
         alu_operand_r   <= 1'b0;
      end else if (state_r == ST_READ) begin
         alu_a_r         <= rf_read(regs_r, ir_rs1_s);
         alu_b_r         <= rf_read(regs_r, ir_rs2_s);
         alu_operation_r <= ir_op_s;
         alu_operand_r   <= ir_operand_s;
      end
   end

   // Writeback outputs; result and flag update even when rd is R0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done_r       <= 1'b0;
         result_out_r <= {WIDTH{1'b0}};
         zero_flag_r  <= 1'b1;
      end else begin
         done_r <= (state_r == ST_EXEC);
         if (state_r == ST_EXEC) begin
            result_out_r <= alu_result;
            zero_flag_r  <= is_zero(alu_result);
         end
      end
   end

`ifdef ISSUE_COUNT_EN
   logic [15:0] retired_count_r;

   assign retired_count = retired_count_r;

   // Retired-instruction counter, wraps naturally at 16 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_count_r <= 16'd0;
      end else if (state_r == ST_EXEC) begin
         retired_count_r <= retired_count_r + 16'd1;
      end
   end
`endif

endmodule
